qam_ser_ber_meter: RTL and testbench
====================================

Name: qam_ser_ber_meter

Overview:
- Parametrised symbol/bit error meter for the QAM test harness.
- Compares receiver sliced symbols against the LFSR reference symbols.
- Auto-searches the reference-to-receiver delay, locks onto it, then counts symbol errors, bit errors and symbols over one or more LFSR periods framed by the LFSR cycle marker.
- Sits on sys_clk, gated by sym_clk_ena, between the LFSR/mapper source and the decision stage of the inphase/quadrature paths.

Parameters:
- SYM_BITS, 4: bits per symbol; legal values 2, 4, 6 (QPSK/16-QAM/64-QAM).
- MAX_DELAY, 16: number of candidate delays searched (taps 0..MAX_DELAY-1).
- ALIGN_LEN, 64: symbols evaluated per candidate delay.
- ALIGN_THRESH, 2: maximum mismatches allowed for a candidate to lock.
- CNT_WIDTH, 22: width of all result counters.
- CONTINUOUS, 0: 0 = single measurement then DONE; 1 = back-to-back measurements.

Ports:
- clk, in, 1: sys_clk.
- reset, in, 1: synchronous, active-high.
- clk_en, in, 1: symbol-rate enable (sym_clk_ena). All state advances only when high.
- start, in, 1: level-sampled request to begin; honoured only in IDLE or DONE.
- ref_sym, in, SYM_BITS: LFSR reference symbol.
- rx_sym, in, SYM_BITS: receiver decision symbol.
- period_start, in, 1: LFSR periodic cycle marker, sampled on clk_en.
- locked, out, 1: high in WAIT_PERIOD and MEASURE.
- lock_delay, out, log2(MAX_DELAY): selected tap.
- lock_fail, out, 1: one-clk pulse when the search exhausts.
- sym_err_count, out, CNT_WIDTH: symbol errors in last window.
- bit_err_count, out, CNT_WIDTH: bit errors in last window.
- sym_count, out, CNT_WIDTH: symbols in last window.
- saturated, out, 1: any counter saturated in last window.
- result_valid, out, 1: one-clk pulse when results update.

Behaviour:
- Reset:
  - State = IDLE.
  - All outputs 0, including lock_delay and the results.
  - Delay line cleared to 0.
  - Reset mid-operation aborts immediately with no result_valid.
- Delay line:
  - Shift register of MAX_DELAY-1 stages, advanced on clk_en.
  - Tap 0 = ref_sym; tap k = ref_sym from k enables earlier.
  - The line keeps shifting in every state.
- Compare:
  - Symbol error = (tap[d] != rx_sym).
  - Bit errors = popcount(tap[d] XOR rx_sym), range 0..SYM_BITS.
- IDLE:
  - On a clk with start=1 -> SEARCH, d=0, trial counters cleared.
- SEARCH:
  - Each clk_en compares with tap d and increments the mismatch count and symbol index.
  - When ALIGN_LEN symbols are done: if mismatches <= ALIGN_THRESH, latch lock_delay=d and go to WAIT_PERIOD.
  - Otherwise, if d = MAX_DELAY-1, pulse lock_fail and go to IDLE.
  - Otherwise d++ and clear the trial counters.
  - The first ALIGN_LEN-window after a new d is used as-is; no flush.
- WAIT_PERIOD:
  - On clk_en with period_start=1 -> MEASURE.
  - Running counters are loaded with that symbol's own comparison, so that symbol is counted.
- MEASURE:
  - Each clk_en adds the comparison to running counters.
  - Counters saturate at 2^CNT_WIDTH-1 and set a sticky sat flag.
  - On the next clk_en with period_start=1, that symbol is not counted:
    - Copy the running counters and sat flag to the outputs.
    - Pulse result_valid on the following clk.
    - If CONTINUOUS=0, go to DONE.
    - If CONTINUOUS=1, stay in MEASURE with the running counters loaded with this symbol's comparison.
- DONE:
  - Holds the outputs and clears locked.
  - start=1 -> SEARCH (full re-search).
- start is ignored in SEARCH, WAIT_PERIOD and MEASURE.
- Without clk_en, nothing changes except the result_valid pulse completing.
- Latency:
  - result_valid is high exactly 1 clk after the closing enable.
  - The outputs are stable from that clk until the next update.

Test Plan:
- rx_sym = ref_sym delayed 5 enables, SYM_BITS=4, error-free, period 1000 symbols -> lock_delay=5, sym_err_count=0, bit_err_count=0, sym_count=1000, single result_valid.
- Same setup with rx bit0 inverted on 10 symbols and bits 0,1 inverted on 3 symbols in the window -> sym_err_count=13, bit_err_count=16.
- rx_sym uncorrelated random (independent LFSR) -> after 16×64 enables, lock_fail pulses once, locked=0, state IDLE, results remain 0.
- CONTINUOUS=1, delay 0, period 200, clean -> result_valid every 200 enables, sym_count=200 each window, no double-counting at boundaries.
- CNT_WIDTH=8, rx all-wrong after lock, period 300 -> sym_err_count=255, sym_count=255, saturated=1.
- Assert reset mid-MEASURE -> next clk all outputs 0, no result_valid; start afterwards re-locks to the correct delay.

Source files
------------

// File: rtl/qam_ser_ber_meter.sv
// qam_ser_ber_meter: searches the reference-to-receiver symbol delay, locks on it, then
// counts symbol errors, bit errors and symbols over LFSR periods framed by period_start_i.
module qam_ser_ber_meter #(
  parameter int SYM_BITS     = 4,
  parameter int MAX_DELAY    = 16,
  parameter int ALIGN_LEN    = 64,
  parameter int ALIGN_THRESH = 2,
  parameter int CNT_WIDTH    = 22,
  parameter bit CONTINUOUS   = 1'b0,
  localparam int DW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en_i,
  input  logic                 start_i,
  input  logic [SYM_BITS-1:0]  ref_sym_i,
  input  logic [SYM_BITS-1:0]  rx_sym_i,
  input  logic                 period_start_i,
  output logic                 locked_o,
  output logic [DW-1:0]        lock_delay_o,
  output logic                 lock_fail_o,
  output logic [CNT_WIDTH-1:0] sym_err_count_o,
  output logic [CNT_WIDTH-1:0] bit_err_count_o,
  output logic [CNT_WIDTH-1:0] sym_count_o,
  output logic                 saturated_o,
  output logic                 result_valid_o
);
  localparam int AW = $clog2(ALIGN_LEN + 1);
  localparam int BW = $clog2(SYM_BITS + 1);
  typedef enum logic [2:0] {IDLE, SEARCH, WAIT_PERIOD, MEASURE, DONE} state_t;
  state_t state_q, state_d;
  logic [SYM_BITS-1:0] line_q [MAX_DELAY-1];
  logic [SYM_BITS-1:0] tap [MAX_DELAY];
  logic [SYM_BITS-1:0] diff;
  logic err;
  logic [BW-1:0] nbit;
  logic [DW-1:0] d_q, d_d, ld_q, ld_d;
  logic [AW-1:0] idx_q, idx_d, mis_q, mis_d, mis_n;
  logic [CNT_WIDTH-1:0] rs_q, rs_d, re_q, re_d, rb_q, rb_d;
  logic [CNT_WIDTH-1:0] se_q, se_d, be_q, be_d, sc_q, sc_d;
  logic [CNT_WIDTH:0] rs_sum, re_sum, rb_sum;
  logic rsat_q, rsat_d, sat_q, sat_d, fail_q, fail_d, rv_q, rv_d;
  assign tap[0] = ref_sym_i;
  for (genvar k = 1; k < MAX_DELAY; k++) begin : g_tap
    assign tap[k] = line_q[k-1];
  end
  assign diff = tap[d_q] ^ rx_sym_i;
  assign err = |diff;
  always_comb begin
    nbit = '0;
    for (int i = 0; i < SYM_BITS; i++) nbit = nbit + BW'(diff[i]);
  end
  assign mis_n = mis_q + AW'(err);
  assign rs_sum = {1'b0, rs_q} + (CNT_WIDTH+1)'(1);
  assign re_sum = {1'b0, re_q} + (CNT_WIDTH+1)'(err);
  assign rb_sum = {1'b0, rb_q} + (CNT_WIDTH+1)'(nbit);
  always_comb begin
    state_d = state_q;
    d_d = d_q;
    idx_d = idx_q;
    mis_d = mis_q;
    rs_d = rs_q;
    re_d = re_q;
    rb_d = rb_q;
    rsat_d = rsat_q;
    ld_d = ld_q;
    se_d = se_q;
    be_d = be_q;
    sc_d = sc_q;
    sat_d = sat_q;
    fail_d = 1'b0;
    rv_d = 1'b0;
    if (clk_en_i) begin
      case (state_q)
        IDLE, DONE: if (start_i) begin
          state_d = SEARCH;
          d_d = '0;
          idx_d = '0;
          mis_d = '0;
        end
        SEARCH: begin
          idx_d = idx_q + AW'(1);
          mis_d = mis_n;
          if (idx_q == AW'(ALIGN_LEN - 1)) begin
            idx_d = '0;
            mis_d = '0;
            if (mis_n <= AW'(ALIGN_THRESH)) begin
              state_d = WAIT_PERIOD;
              ld_d = d_q;
            end else if (d_q == DW'(MAX_DELAY - 1)) begin
              state_d = IDLE;
              fail_d = 1'b1;
            end else d_d = d_q + DW'(1);
          end
        end
        WAIT_PERIOD: if (period_start_i) begin
          state_d = MEASURE;
          rs_d = CNT_WIDTH'(1);
          re_d = CNT_WIDTH'(err);
          rb_d = CNT_WIDTH'(nbit);
          rsat_d = 1'b0;
        end
        MEASURE: if (period_start_i) begin
          // the closing symbol belongs to the next window, not this one
          se_d = re_q;
          be_d = rb_q;
          sc_d = rs_q;
          sat_d = rsat_q;
          rv_d = 1'b1;
          state_d = CONTINUOUS ? MEASURE : DONE;
          rs_d = CNT_WIDTH'(1);
          re_d = CNT_WIDTH'(err);
          rb_d = CNT_WIDTH'(nbit);
          rsat_d = 1'b0;
        end else begin
          rs_d = rs_sum[CNT_WIDTH] ? '1 : rs_sum[CNT_WIDTH-1:0];
          re_d = re_sum[CNT_WIDTH] ? '1 : re_sum[CNT_WIDTH-1:0];
          rb_d = rb_sum[CNT_WIDTH] ? '1 : rb_sum[CNT_WIDTH-1:0];
          rsat_d = rsat_q | rs_sum[CNT_WIDTH] | re_sum[CNT_WIDTH] | rb_sum[CNT_WIDTH];
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      d_q <= '0;
      idx_q <= '0;
      mis_q <= '0;
      rs_q <= '0;
      re_q <= '0;
      rb_q <= '0;
      rsat_q <= 1'b0;
      ld_q <= '0;
      se_q <= '0;
      be_q <= '0;
      sc_q <= '0;
      sat_q <= 1'b0;
      fail_q <= 1'b0;
      rv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q <= d_d;
      idx_q <= idx_d;
      mis_q <= mis_d;
      rs_q <= rs_d;
      re_q <= re_d;
      rb_q <= rb_d;
      rsat_q <= rsat_d;
      ld_q <= ld_d;
      se_q <= se_d;
      be_q <= be_d;
      sc_q <= sc_d;
      sat_q <= sat_d;
      fail_q <= fail_d;
      rv_q <= rv_d;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) for (int i = 0; i < MAX_DELAY - 1; i++) line_q[i] <= '0;
    else if (clk_en_i) begin
      line_q[0] <= ref_sym_i;
      for (int i = 1; i < MAX_DELAY - 1; i++) line_q[i] <= line_q[i-1];
    end
  end
  assign locked_o = (state_q == WAIT_PERIOD) || (state_q == MEASURE);
  assign lock_delay_o = ld_q;
  assign lock_fail_o = fail_q;
  assign sym_err_count_o = se_q;
  assign bit_err_count_o = be_q;
  assign sym_count_o = sc_q;
  assign saturated_o = sat_q;
  assign result_valid_o = rv_q;
endmodule

// File: tb/tb_qam_ser_ber_meter.sv
// tb_qam_ser_ber_meter: two meters (single-shot 22-bit, continuous 8-bit) checked against a
// history-based model of the search and measurement windows.
module tb_qam_ser_ber_meter;
  localparam int CWA = 22, CWB = 8, N = 40000;
  logic clk = 1'b0, reset = 1'b1, clk_en = 1'b0;
  logic [3:0] ref_sym = '0, rx_a = '0, rx_b = '0;
  logic start_a = 1'b0, start_b = 1'b0, ps_a = 1'b0, ps_b = 1'b0;
  logic lk_a, lf_a, sat_a, rv_a, lk_b, lf_b, sat_b, rv_b;
  logic [3:0] ld_a, ld_b;
  logic [CWA-1:0] se_a, be_a, sc_a;
  logic [CWB-1:0] se_b, be_b, sc_b;
  int total = 0, bad = 0;
  bit armed = 1'b0;
  always #5 clk = ~clk;
  qam_ser_ber_meter #(.CNT_WIDTH(CWA), .CONTINUOUS(1'b0)) dut_a (
    .clk(clk), .reset(reset), .clk_en_i(clk_en), .start_i(start_a), .ref_sym_i(ref_sym),
    .rx_sym_i(rx_a), .period_start_i(ps_a), .locked_o(lk_a), .lock_delay_o(ld_a),
    .lock_fail_o(lf_a), .sym_err_count_o(se_a), .bit_err_count_o(be_a), .sym_count_o(sc_a),
    .saturated_o(sat_a), .result_valid_o(rv_a));
  qam_ser_ber_meter #(.CNT_WIDTH(CWB), .CONTINUOUS(1'b1)) dut_b (
    .clk(clk), .reset(reset), .clk_en_i(clk_en), .start_i(start_b), .ref_sym_i(ref_sym),
    .rx_sym_i(rx_b), .period_start_i(ps_b), .locked_o(lk_b), .lock_delay_o(ld_b),
    .lock_fail_o(lf_b), .sym_err_count_o(se_b), .bit_err_count_o(be_b), .sym_count_o(sc_b),
    .saturated_o(sat_b), .result_valid_o(rv_b));
  // model: enable history since reset; windows are evaluated over that history
  int refh [N];
  int rxh [2][N];
  int n = 0;
  int mode [2], md [2], ws [2], ms [2], mld [2];
  longint mse [2], mbe [2], msc [2];
  bit mlf [2], mrv [2], msat [2];
  int mcw [2] = '{CWA, CWB};
  bit mcont [2] = '{1'b0, 1'b1};
  function automatic int tapv(input int d, input int j);
    return (j - d >= 0) ? refh[j-d] : 0;
  endfunction
  task automatic mstep(input int i, input bit st, input bit ps);
    int cnt;
    longint sc, se, sb, mx;
    logic [3:0] x;
    case (mode[i])
      0, 4: if (st) begin mode[i] = 1; md[i] = 0; ws[i] = n + 1; end
      1: if (n - ws[i] + 1 == 64) begin
        cnt = 0;
        for (int j = ws[i]; j <= n; j++) if (tapv(md[i], j) != rxh[i][j]) cnt++;
        if (cnt <= 2) begin mode[i] = 2; mld[i] = md[i]; end
        else if (md[i] == 15) begin mode[i] = 0; mlf[i] = 1'b1; end
        else begin md[i]++; ws[i] = n + 1; end
      end
      2: if (ps) begin mode[i] = 3; ms[i] = n; end
      3: if (ps) begin
        sc = 0; se = 0; sb = 0;
        for (int j = ms[i]; j < n; j++) begin
          x = 4'(tapv(md[i], j) ^ rxh[i][j]);
          sc++;
          se += (x != 0) ? 1 : 0;
          sb += $countones(x);
        end
        mx = (longint'(1) << mcw[i]) - 1;
        msc[i] = (sc > mx) ? mx : sc;
        mse[i] = (se > mx) ? mx : se;
        mbe[i] = (sb > mx) ? mx : sb;
        msat[i] = (sc > mx) || (se > mx) || (sb > mx);
        mrv[i] = 1'b1;
        if (mcont[i]) ms[i] = n; else mode[i] = 4;
      end
      default: ;
    endcase
  endtask
  always @(posedge clk) begin
    mlf = '{1'b0, 1'b0};
    mrv = '{1'b0, 1'b0};
    if (reset) begin
      n = 0;
      for (int i = 0; i < 2; i++) begin
        mode[i] = 0; md[i] = 0; mld[i] = 0; mse[i] = 0; mbe[i] = 0; msc[i] = 0; msat[i] = 1'b0;
      end
    end else if (clk_en) begin
      if (n >= N - 1) begin $display("FAIL model_history n=%0d limit=%0d", n, N); $fatal; end
      refh[n] = int'(ref_sym);
      rxh[0][n] = int'(rx_a);
      rxh[1][n] = int'(rx_b);
      mstep(0, start_a, ps_a);
      mstep(1, start_b, ps_b);
      n++;
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (armed) begin
    chk("A.locked", lk_a, mode[0] == 2 || mode[0] == 3);
    chk("A.lock_delay", ld_a, mld[0]);
    chk("A.lock_fail", lf_a, mlf[0]);
    chk("A.sym_err", se_a, mse[0]);
    chk("A.bit_err", be_a, mbe[0]);
    chk("A.sym_count", sc_a, msc[0]);
    chk("A.saturated", sat_a, msat[0]);
    chk("A.result_valid", rv_a, mrv[0]);
    chk("B.locked", lk_b, mode[1] == 2 || mode[1] == 3);
    chk("B.lock_delay", ld_b, mld[1]);
    chk("B.lock_fail", lf_b, mlf[1]);
    chk("B.sym_err", se_b, mse[1]);
    chk("B.bit_err", be_b, mbe[1]);
    chk("B.sym_count", sc_b, msc[1]);
    chk("B.saturated", sat_b, msat[1]);
    chk("B.result_valid", rv_b, mrv[1]);
  end
  // stimulus state
  int drv [N];
  int k = 0, kb = 0, pa = 1000, pb = 200, da = 5, rxmode_a = 0, rxmode_b = 0;
  bit inj = 1'b0, gaps = 1'b0;
  task automatic tick(input bit sa, input bit sb);
    int pos;
    @(negedge clk);
    start_a = sa;
    start_b = sb;
    clk_en = (sa || sb || !gaps) ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (clk_en) begin
      ref_sym = 4'($urandom_range(0, 15));
      drv[k] = int'(ref_sym);
      ps_a = (k % pa) == 0;
      ps_b = (kb % pb) == 0;
      if (rxmode_a == 0) rx_a = 4'($urandom_range(0, 15));
      else begin
        rx_a = (k >= da) ? 4'(drv[k-da]) : 4'd0;
        pos = k % pa;
        if (inj && (mode[0] == 2 || mode[0] == 3)) begin
          if (pos >= 500 && pos < 510) rx_a ^= 4'd1;
          else if (pos >= 700 && pos < 703) rx_a ^= 4'd3;
        end
      end
      rx_b = rxmode_b != 0 ? ~ref_sym : ref_sym;
      k++;
      kb++;
    end
  endtask
  function automatic logic sig(input int w);
    return (w == 0) ? rv_a : (w == 1) ? rv_b : lk_a;
  endfunction
  task automatic wait_pulse(input int which, input int maxc, input string nm, output int c);
    c = 0;
    do begin tick(1'b0, 1'b0); c++; end while (c < maxc && !sig(which));
    chk({nm, ".seen"}, sig(which), 1);
  endtask
  initial begin
    int c, nf, nr;
    repeat (4) tick(1'b0, 1'b0);
    armed = 1'b1;
    reset = 1'b0;
    chk("rst.locked", lk_a, 0);
    chk("rst.lock_delay", ld_a, 0);
    chk("rst.sym_count", sc_a, 0);
    chk("rst.result_valid", rv_a, 0);
    repeat (20) tick(1'b0, 1'b0);
    rxmode_a = 0;
    tick(1'b1, 1'b0);
    nf = 0;
    repeat (1300) begin tick(1'b0, 1'b0); nf += int'(lf_a); end
    chk("fail.pulses", nf, 1);
    chk("fail.locked", lk_a, 0);
    chk("fail.lock_delay", ld_a, 0);
    chk("fail.sym_count", sc_a, 0);
    rxmode_a = 1; da = 5; gaps = 1'b1;
    tick(1'b1, 1'b0);
    wait_pulse(0, 8000, "clean.rv", c);
    chk("clean.lock_delay", ld_a, 5);
    chk("clean.sym_err", se_a, 0);
    chk("clean.bit_err", be_a, 0);
    chk("clean.sym_count", sc_a, 1000);
    chk("clean.saturated", sat_a, 0);
    nr = 0;
    repeat (1500) begin tick(1'b0, 1'b0); nr += int'(rv_a); end
    chk("clean.extra_rv", nr, 0);
    chk("clean.done_locked", lk_a, 0);
    gaps = 1'b0; inj = 1'b1;
    tick(1'b1, 1'b0);
    wait_pulse(0, 5000, "err.rv", c);
    chk("err.sym_err", se_a, 13);
    chk("err.bit_err", be_a, 16);
    chk("err.sym_count", sc_a, 1000);
    inj = 1'b0;
    kb = 0; pb = 200; rxmode_b = 0;
    tick(1'b0, 1'b1);
    wait_pulse(1, 2000, "cont.rv0", c);
    chk("cont.sym_count0", sc_b, 200);
    for (int w = 0; w < 2; w++) begin
      wait_pulse(1, 400, "cont.rv", c);
      chk("cont.spacing", c, 200);
      chk("cont.sym_count", sc_b, 200);
      chk("cont.sym_err", se_b, 0);
      chk("cont.bit_err", be_b, 0);
    end
    rxmode_b = 1; pb = 300; kb = 0;
    wait_pulse(1, 10, "sat.rv0", c);
    wait_pulse(1, 400, "sat.rv1", c);
    chk("sat.spacing", c, 300);
    chk("sat.sym_err", se_b, 255);
    chk("sat.sym_count", sc_b, 255);
    chk("sat.bit_err", be_b, 255);
    chk("sat.saturated", sat_b, 1);
    da = 5;
    tick(1'b1, 1'b0);
    wait_pulse(2, 1000, "mid.lock", c);
    c = 0;
    do begin tick(1'b0, 1'b0); c++; end while (k % pa != 1 && c < 1200);
    repeat (50) tick(1'b0, 1'b0);
    chk("mid.locked", lk_a, 1);
    reset = 1'b1;
    tick(1'b0, 1'b0);
    reset = 1'b0;
    chk("mid.rst_locked", lk_a, 0);
    chk("mid.rst_lock_delay", ld_a, 0);
    chk("mid.rst_sym_err", se_a, 0);
    chk("mid.rst_sym_count", sc_a, 0);
    chk("mid.rst_rv", rv_a, 0);
    chk("mid.rst_b_count", sc_b, 0);
    da = 9;
    repeat (5) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    wait_pulse(0, 5000, "relock.rv", c);
    chk("relock.lock_delay", ld_a, 9);
    chk("relock.sym_count", sc_a, 1000);
    chk("relock.sym_err", se_a, 0);
    chk("relock.bit_err", be_a, 0);
    repeat (3) tick(1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
